immediate_extractor: RTL and testbench



---
 rtl/imm_pkg.sv | 15 +
 rtl/imm_decode_comb.sv | 34 +++
 rtl/immediate_extractor.sv | 43 ++++
 tb/tb_immediate_extractor.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// Shared constants for the RV32I immediate extractor: format-select encodings and datapath width.
package imm_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] IMM_NONE  = 3'd0;
    localparam logic [2:0] IMM_I     = 3'd1;
    localparam logic [2:0] IMM_U     = 3'd2;
    localparam logic [2:0] IMM_S     = 3'd3;
    localparam logic [2:0] IMM_B     = 3'd4;
    localparam logic [2:0] IMM_J     = 3'd5;
    localparam logic [2:0] IMM_SHAMT = 3'd6;
    localparam logic [2:0] IMM_ZIMM  = 3'd7;

endpackage

// File: rtl/imm_decode_comb.sv
// Purpose: combinational RV32I immediate extraction from instruction word and format select.
// Latency: zero (pure combinational).
// Backpressure: none; output follows inputs continuously.
module imm_decode_comb
    import imm_pkg::*;
(
    input  logic [31:0] instruction,
    input  logic [2:0]  selection,
    output logic [31:0] imm
);

    logic sign;

    assign sign = instruction[31];

    // Opcode is deliberately ignored; the control unit owns the format choice.
    always_comb begin
        imm = '0;
        case (selection)
            IMM_NONE:  imm = '0;
            IMM_I:     imm = {{20{sign}}, instruction[31:20]};
            IMM_U:     imm = {instruction[31:12], 12'b0};
            IMM_S:     imm = {{20{sign}}, instruction[31:25], instruction[11:7]};
            IMM_B:     imm = {{19{sign}}, instruction[31], instruction[7],
                              instruction[30:25], instruction[11:8], 1'b0};
            IMM_J:     imm = {{11{sign}}, instruction[31], instruction[19:12],
                              instruction[20], instruction[30:21], 1'b0};
            IMM_SHAMT: imm = {27'b0, instruction[24:20]};
            IMM_ZIMM:  imm = {27'b0, instruction[19:15]};
            default:   imm = '0;
        endcase
    end

endmodule

// File: rtl/immediate_extractor.sv
// Purpose: decode-stage immediate extractor; IMM_COMB_OUT_EN selects a zero-latency bypass instead of the register.
// Latency: 1 cycle registered (default), 0 with IMM_COMB_OUT_EN; synchronous active-low reset.
// Backpressure: EN low holds VALUE; no ready/valid handshake.
module immediate_extractor #(
    parameter int XLEN = imm_pkg::XLEN
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic            EN,
    input  logic [XLEN-1:0] INSTRUCTION,
    input  logic [2:0]      SELECTION,
    output logic [XLEN-1:0] VALUE
);

    logic [XLEN-1:0] imm_d;

    imm_decode_comb u_decode (
        .instruction (INSTRUCTION),
        .selection   (SELECTION),
        .imm         (imm_d)
    );

`ifdef IMM_COMB_OUT_EN
    // Clock, reset and enable are kept on the boundary so both builds share one footprint.
    logic unused_ctrl;
    assign unused_ctrl = &{1'b0, CLK, RESET_N, EN};
    assign VALUE = imm_d;
`else
    logic [XLEN-1:0] value_q;

    // Reset outranks enable so a mid-stream reset always clears the output.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            value_q <= '0;
        end else if (EN) begin
            value_q <= imm_d;
        end
    end

    assign VALUE = value_q;
`endif

endmodule

// File: tb/tb_immediate_extractor.sv
// Self-checking bench for immediate_extractor: directed steps plus random traffic through a queue scoreboard.
module tb_immediate_extractor;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [31:0] instr;
    logic [2:0]  sel;
    logic [31:0] value;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];
    logic [31:0] model_reg;

    immediate_extractor dut (
        .CLK         (clk),
        .RESET_N     (rst_n),
        .EN          (en),
        .INSTRUCTION (instr),
        .SELECTION   (sel),
        .VALUE       (value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference built from shifts and masks of the whole word.
    function automatic logic [31:0] imm_ref(input logic [31:0] i, input logic [2:0] s);
        logic signed [31:0] si;
        logic [31:0] sh20, sh19, sh11;
        si   = i;
        sh20 = si >>> 20;
        sh19 = si >>> 19;
        sh11 = si >>> 11;
        case (s)
            3'd1:    return sh20;
            3'd2:    return i & 32'hFFFF_F000;
            3'd3:    return (sh20 & ~32'h1F) | ((i >> 7) & 32'h1F);
            3'd4:    return (sh19 & 32'hFFFF_F000) | ((i << 4) & 32'h800)
                          | ((i >> 20) & 32'h7E0) | ((i >> 7) & 32'h1E);
            3'd5:    return (sh11 & 32'hFFF0_0000) | (i & 32'h000F_F000)
                          | ((i >> 9) & 32'h800) | ((i >> 20) & 32'h7FE);
            3'd6:    return (i >> 20) & 32'h1F;
            3'd7:    return (i >> 15) & 32'h1F;
            default: return 32'h0;
        endcase
    endfunction

    task automatic check_out();
        logic [31:0] e;
        string       t;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty: got %h required an expected entry", value);
            return;
        end
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        checks++;
        assert (value === e) else begin
            errors++;
            $error("FAIL %s: got %h required %h", t, value, e);
        end
    endtask

    // Drive one cycle, push the explicit expectation, then check after the edge.
    task automatic step(input string tag, input logic r, input logic e,
                        input logic [31:0] i, input logic [2:0] s, input logic [31:0] expv);
        rst_n = r;
        en    = e;
        instr = i;
        sel   = s;
        exp_q.push_back(expv);
        tag_q.push_back(tag);
        if (!r)     model_reg = 32'h0;
        else if (e) model_reg = expv;
        @(posedge clk);
        #1;
        check_out();
    endtask

    // Same as step but the expectation comes from the reference model.
    task automatic step_model(input string tag, input logic r, input logic e,
                              input logic [31:0] i, input logic [2:0] s);
        logic [31:0] nxt;
        if (!r)     nxt = 32'h0;
        else if (e) nxt = imm_ref(i, s);
        else        nxt = model_reg;
        step(tag, r, e, i, s, nxt);
    endtask

    initial begin
        rst_n     = 1'b0;
        en        = 1'b1;
        instr     = 32'hFFFF_FFFF;
        sel       = 3'd1;
        model_reg = 32'h0;
        @(negedge clk);

        step("reset_edge1", 1'b0, 1'b1, 32'hFFFF_FFFF, 3'd1, 32'h0);
        step("reset_edge2", 1'b0, 1'b1, 32'hFFFF_FFFF, 3'd1, 32'h0);
        step("release_i_minus1", 1'b1, 1'b1, 32'hFFFF_FFFF, 3'd1, 32'hFFFF_FFFF);

        step("i_addi_10",   1'b1, 1'b1, 32'h00A0_0613, 3'd1, 32'd10);
        step("u_lui_4096",  1'b1, 1'b1, 32'h0000_1337, 3'd2, 32'd4096);
        step("s_sw_7",      1'b1, 1'b1, 32'h00B3_23A3, 3'd3, 32'd7);
        step("b_blt_m12",   1'b1, 1'b1, 32'hFEC5_CAE3, 3'd4, 32'hFFFF_FFF4);
        step("j_jal_1024",  1'b1, 1'b1, 32'h4000_006F, 3'd5, 32'd1024);
        step("j_most_neg",  1'b1, 1'b1, 32'h8000_006F, 3'd5, 32'hFFF0_0000);
        step("shamt_31",    1'b1, 1'b1, 32'h41F3_5313, 3'd6, 32'd31);
        step("zimm_31",     1'b1, 1'b1, 32'h340F_D073, 3'd7, 32'd31);
        step("none_ones",   1'b1, 1'b1, 32'hFFFF_FFFF, 3'd0, 32'd0);
        step("shamt_no_sext", 1'b1, 1'b1, 32'hFFFF_FFFF, 3'd6, 32'd31);
        step("u_neg",       1'b1, 1'b1, 32'hFFFF_FFFF, 3'd2, 32'hFFFF_F000);

        step("hold_cap_10", 1'b1, 1'b1, 32'h00A0_0613, 3'd1, 32'd10);
        for (int k = 0; k < 3; k++) begin
            step("hold_en_low", 1'b1, 1'b0, 32'hFEC5_CAE3, 3'd4, 32'd10);
        end
        step("hold_release", 1'b1, 1'b1, 32'hFEC5_CAE3, 3'd4, 32'hFFFF_FFF4);

        step("midreset_en_low", 1'b0, 1'b0, 32'hFFFF_FFFF, 3'd1, 32'h0);
        step("post_reset_en_low", 1'b1, 1'b0, 32'hFFFF_FFFF, 3'd1, 32'h0);
        step("first_capture", 1'b1, 1'b1, 32'h4000_006F, 3'd5, 32'd1024);

        for (int k = 0; k < 200; k++) begin
            step_model("random", ($urandom_range(0, 19) != 0), ($urandom_range(0, 3) != 0),
                       $urandom, 3'($urandom_range(0, 7)));
        end

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_drain: got %0d leftover entries required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no completion required finish before 100000");
        $fatal(1, "timeout");
    end

endmodule
